// File: rtl/multicycle_sequencer_pkg.sv
// Shared types and encodings for the multi-cycle RV32 sequencer.
package multicycle_sequencer_pkg;

   // FSM states; the encoding is exported on the debug state port.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      MEM    = 3'd4,
      WB     = 3'd5,
      HALT   = 3'd6
   } seq_state_t;

   // PC source select
   localparam logic [1:0] PC_PLUS4  = 2'd0;
   localparam logic [1:0] PC_TARGET = 2'd1;
   localparam logic [1:0] PC_ALU    = 2'd2;

   // Register write-back source select
   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_PC4 = 2'd2;

   // Sticky fault codes
   localparam logic [1:0] FLT_NONE    = 2'd0;
   localparam logic [1:0] FLT_ILLEGAL = 2'd1;
   localparam logic [1:0] FLT_TIMEOUT = 2'd2;

   // Width of the memory-wait counter; covers MEM_TIMEOUT up to 2^16-1.
   localparam int WDOG_W = 16;

   // State entered after the cycle that retires an instruction (pc_we).
   function automatic seq_state_t after_retire(input logic run);
      return run ? FETCH : IDLE;
   endfunction

endpackage

// File: rtl/multicycle_sequencer_watchdog.sv
// Saturating counter of consecutive memory wait cycles; flags expiry on the
// cycle that would be the MEM_TIMEOUT-th consecutive wait.
module seq_watchdog
   import multicycle_sequencer_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic waiting,
   input  logic clear,
   output logic expired
);

   localparam logic [WDOG_W-1:0] LAST = WDOG_W'(MEM_TIMEOUT - 1);

   logic [WDOG_W-1:0] cnt_q;
   logic [WDOG_W-1:0] cnt_d;

   // Next count: clear wins, otherwise advance while waiting, stop at LAST.
   always_comb begin
      // NOTE: assign a default before any branch so every path drives cnt_d and no latch is inferred.
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (waiting && (cnt_q != LAST)) begin
         cnt_d = cnt_q + WDOG_W'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // A ready in the same cycle clears instead of expiring.
   assign expired = waiting && !clear && (cnt_q == LAST);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FSM sequencing the RV32 datapath through FETCH, DECODE, EXEC,
// MEM and WB over a single shared memory port, with a memory watchdog and
// cycle / retired-instruction counters.
module multicycle_sequencer
   import multicycle_sequencer_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             dec_valid,
   input  logic             dec_reg_write,
   input  logic             dec_mem_read,
   input  logic             dec_mem_write,
   input  logic             dec_is_jump,
   input  logic             dec_is_branch,
   input  logic             dec_is_jalr,
   input  logic             branch_taken,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             mem_addr_sel,
   output logic             ir_we,
   output logic             mdr_we,
   output logic             pc_we,
   output logic [1:0]       pc_sel,
   output logic             rf_we,
   output logic [1:0]       wb_sel,
   output logic [2:0]       state,
   output logic             halted,
   output logic [1:0]       fault,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instret_cnt
);

   seq_state_t       state_q, state_d;
   logic [1:0]       fault_q, fault_d;
   logic [CNT_W-1:0] cycle_cnt_q, instret_cnt_q;
   logic             mem_phase;
   logic             busy;
   logic             wd_waiting;
   logic             wd_clear;
   logic             wd_expired;

   // Memory is owned only in FETCH and MEM; waits are counted only there.
   assign mem_phase  = (state_q == FETCH) || (state_q == MEM);
   assign busy       = (state_q != IDLE) && (state_q != HALT);
   assign wd_waiting = mem_phase && !mem_ready;
   assign wd_clear   = mem_ready || !mem_phase;

   seq_watchdog #(
      .MEM_TIMEOUT(MEM_TIMEOUT)
   ) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .waiting (wd_waiting),
      .clear   (wd_clear),
      .expired (wd_expired)
   );

   // Next-state and Moore-decoded strobes; completion strobes gated by mem_ready.
   always_comb begin
      state_d      = state_q;
      fault_d      = fault_q;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_we        = 1'b0;
      mdr_we       = 1'b0;
      pc_we        = 1'b0;
      pc_sel       = PC_PLUS4;
      rf_we        = 1'b0;
      wb_sel       = WB_ALU;

      case (state_q)
         IDLE: begin
            if (run) begin
               state_d = FETCH;
            end
         end

         FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_we   = 1'b1;
               state_d = DECODE;
            end else if (wd_expired) begin
               state_d = HALT;
               fault_d = FLT_TIMEOUT;
            end
         end

         DECODE: begin
            if (!dec_valid) begin
               state_d = HALT;
               fault_d = FLT_ILLEGAL;
            end else begin
               state_d = EXEC;
            end
         end

         EXEC: begin
            if (dec_is_branch) begin
               pc_we   = 1'b1;
               pc_sel  = branch_taken ? PC_TARGET : PC_PLUS4;
               state_d = after_retire(run);
            end else if (dec_mem_read || dec_mem_write) begin
               state_d = MEM;
            end else begin
               state_d = WB;
            end
         end

         MEM: begin
            mem_req      = 1'b1;
            mem_addr_sel = 1'b1;
            mem_we       = dec_mem_write;
            if (mem_ready) begin
               if (dec_mem_write) begin
                  pc_we   = 1'b1;
                  state_d = after_retire(run);
               end else begin
                  mdr_we  = 1'b1;
                  state_d = WB;
               end
            end else if (wd_expired) begin
               state_d = HALT;
               fault_d = FLT_TIMEOUT;
            end
         end

         WB: begin
            rf_we = dec_reg_write;
            pc_we = 1'b1;
            if (dec_mem_read) begin
               wb_sel = WB_MEM;
            end else if (dec_is_jump) begin
               wb_sel = WB_PC4;
            end
            if (dec_is_jump && dec_is_jalr) begin
               pc_sel = PC_ALU;
            end else if (dec_is_jump) begin
               pc_sel = PC_TARGET;
            end
            state_d = after_retire(run);
         end

         HALT: begin
            state_d = HALT;
         end

         default: begin
            state_d = HALT;
            fault_d = FLT_ILLEGAL;
         end
      endcase
   end

   // State, sticky fault and counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         fault_q       <= FLT_NONE;
         cycle_cnt_q   <= '0;
         instret_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         fault_q <= fault_d;
         if (busy) begin
            cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
         end
         if (pc_we) begin
            instret_cnt_q <= instret_cnt_q + CNT_W'(1);
         end
      end
   end

   assign state       = state_q;
   assign halted      = (state_q == HALT);
   assign fault       = fault_q;
   assign cycle_cnt   = cycle_cnt_q;
   assign instret_cnt = instret_cnt_q;

endmodule
